// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles everything that connects the two client units and the shared ALU
// to alu_arbiter.
//   reqN_valid/ready/aluop/a/b  : operation handshake from requester N
//   respN_valid/f/illegal       : one-cycle result pulse back to requester N
//   alu_valid_i/aluop/a/b       : operation presented to the ALU
//   alu_f/alu_valid_o           : ALU result returning after ALU_LAT cycles
// Modports:
//   slave  : the arbiter side
//   master : the client/ALU side (requesters, response sinks and ALU)
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_aluop;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_aluop;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        resp0_valid;
  logic [31:0] resp0_f;
  logic        resp0_illegal;

  logic        resp1_valid;
  logic [31:0] resp1_f;
  logic        resp1_illegal;

  logic        alu_valid_i;
  logic [2:0]  alu_aluop;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_f;
  logic        alu_valid_o;

  modport slave (
    input  req0_valid, req0_aluop, req0_a, req0_b,
    input  req1_valid, req1_aluop, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_f, resp0_illegal,
    output resp1_valid, resp1_f, resp1_illegal,
    output alu_valid_i, alu_aluop, alu_a, alu_b,
    input  alu_f, alu_valid_o
  );

  modport master (
    output req0_valid, req0_aluop, req0_a, req0_b,
    output req1_valid, req1_aluop, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_f, resp0_illegal,
    input  resp1_valid, resp1_f, resp1_illegal,
    input  alu_valid_i, alu_aluop, alu_a, alu_b,
    output alu_f, alu_valid_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter sharing one fixed-latency pipelined ALU between two
// requesters. The winner's operation is driven onto the ALU combinationally;
// a tag pipeline of ALU_LAT stages follows each operation so the result can
// be routed back to its issuer one cycle after the ALU produces it.
// Illegal opcode (7) operations take an arbitration slot but are never shown
// to the ALU; they return a zero result flagged as illegal.
//
// Parameters:
//   ALU_LAT : ALU latency in cycles (>= 1)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : alu_arbiter_if.slave (requests, responses, ALU connection)
//   err   : sticky flag, ALU valid disagreed with the tag pipeline
// Optional build macro ALU_ARB_PERF_EN adds:
//   perf_grant0, perf_grant1 : grant counts per requester
//   perf_conflict            : cycles with both requesters valid
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus,
  output logic           err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]    perf_grant0,
  output logic [31:0]    perf_grant1,
  output logic [31:0]    perf_conflict
`endif
);

  localparam int         CNT_W      = $clog2(ALU_LAT + 1);
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  logic        prio;
  logic        gnt0;
  logic        gnt1;
  logic        gnt;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_ill;

  logic        tag_vld_p [ALU_LAT];
  logic        tag_id_p  [ALU_LAT];
  logic        tag_ill_p [ALU_LAT];

  logic        last_vld;
  logic        last_id;
  logic        last_ill;
  logic        sel0;
  logic        sel1;

  logic [CNT_W-1:0] mask_cnt;
  logic             check_en;
  logic             exp_alu_vld;

  // Arbitration and ALU drive (combinational, cycle t)
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    if (!rst) begin
      // A lone requester always wins; on contention prio decides.
      gnt0 = bus.req0_valid && (!bus.req1_valid || !prio);
      gnt1 = bus.req1_valid && (!bus.req0_valid ||  prio);
    end
    gnt = gnt0 || gnt1;
    if (gnt0) begin
      sel_op = bus.req0_aluop;
      sel_a  = bus.req0_a;
      sel_b  = bus.req0_b;
    end else if (gnt1) begin
      sel_op = bus.req1_aluop;
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
    end
    sel_ill = gnt && (sel_op == OP_ILLEGAL);
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.alu_valid_i = gnt && !sel_ill;
  assign bus.alu_aluop   = sel_op;
  assign bus.alu_a       = sel_a;
  assign bus.alu_b       = sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end

  // Tag pipeline p0..p(ALU_LAT-1), aligned with the ALU's internal stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        tag_vld_p[i] <= 1'b0;
      end
    end else begin
      tag_vld_p[0] <= gnt;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
    end
  end

  // id/illegal are only meaningful alongside vld, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_id_p[0]  <= gnt1;
    tag_ill_p[0] <= sel_ill;
    for (int i = 1; i < ALU_LAT; i++) begin
      tag_id_p[i]  <= tag_id_p[i-1];
      tag_ill_p[i] <= tag_ill_p[i-1];
    end
  end

  assign last_vld = tag_vld_p[ALU_LAT-1];
  assign last_id  = tag_id_p[ALU_LAT-1];
  assign last_ill = tag_ill_p[ALU_LAT-1];
  assign sel0     = last_vld && !last_id;
  assign sel1     = last_vld &&  last_id;

  // Response stage: registered one cycle after the ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp0_valid   <= 1'b0;
      bus.resp0_illegal <= 1'b0;
      bus.resp0_f       <= '0;
      bus.resp1_valid   <= 1'b0;
      bus.resp1_illegal <= 1'b0;
      bus.resp1_f       <= '0;
    end else begin
      bus.resp0_valid   <= sel0;
      bus.resp0_illegal <= sel0 && last_ill;
      bus.resp1_valid   <= sel1;
      bus.resp1_illegal <= sel1 && last_ill;
      // The unselected result holds its last value.
      if (sel0) begin
        bus.resp0_f <= last_ill ? 32'h0 : bus.alu_f;
      end
      if (sel1) begin
        bus.resp1_f <= last_ill ? 32'h0 : bus.alu_f;
      end
    end
  end

  // The ALU's valid pipeline is not reset, so operations dropped by rst can
  // still emerge for ALU_LAT cycles; the consistency check ignores them.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt <= CNT_W'(ALU_LAT);
    end else if (mask_cnt != '0) begin
      mask_cnt <= mask_cnt - CNT_W'(1);
    end
  end

  assign check_en    = (mask_cnt == '0);
  assign exp_alu_vld = last_vld && !last_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (check_en && (bus.alu_valid_o != exp_alu_vld)) begin
      err <= 1'b1;
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt0) begin
        perf_grant0 <= perf_grant0 + 32'd1;
      end
      if (gnt1) begin
        perf_grant1 <= perf_grant1 + 32'd1;
      end
      if (bus.req0_valid && bus.req1_valid) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Bench for alu_arbiter with a 2-stage behavioural ALU (no reset on its
// pipeline). Opcodes of the bench ALU: 0 add, 1 and, 2 or, 3 xor, 4 sub,
// 5 shift left, 6 shift right.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  logic err;
  logic inj;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0;
  logic [31:0] perf_grant1;
  logic [31:0] perf_conflict;
`endif

  alu_arbiter_if bus ();

  alu_arbiter #(.ALU_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a - b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  logic        s1_v = 1'b0;
  logic        s2_v = 1'b0;
  logic [31:0] s1_f = 32'h0;
  logic [31:0] s2_f = 32'h0;

  always_ff @(posedge clk) begin
    s1_v <= bus.alu_valid_i;
    s1_f <= alu_fn(bus.alu_aluop, bus.alu_a, bus.alu_b);
    s2_v <= s1_v;
    s2_f <= s1_f;
  end

  assign bus.alu_f       = s2_f;
  assign bus.alu_valid_o = s2_v | inj;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rdy0;
    logic        rdy1;
    logic        avi;
    logic        rv0;
    logic [31:0] rf0;
    logic        ril0;
    logic        rv1;
    logic [31:0] rf1;
    logic        ril1;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void row(int r, int v0, int op0, int a0, int b0,
                              int v1, int op1, int a1, int b1,
                              int rdy0, int rdy1, int avi,
                              int rv0, int rf0, int ril0, int rv1, int rf1, int ril1);
    vec_t v;
    v.rst  = 1'(r);
    v.v0   = 1'(v0);   v.op0 = 3'(op0); v.a0 = 32'(a0); v.b0 = 32'(b0);
    v.v1   = 1'(v1);   v.op1 = 3'(op1); v.a1 = 32'(a1); v.b1 = 32'(b1);
    v.rdy0 = 1'(rdy0); v.rdy1 = 1'(rdy1); v.avi = 1'(avi);
    v.rv0  = 1'(rv0);  v.rf0 = 32'(rf0); v.ril0 = 1'(ril0);
    v.rv1  = 1'(rv1);  v.rf1 = 32'(rf1); v.ril1 = 1'(ril1);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [2:0] op0,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [2:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1);
    rst            = r;
    bus.req0_valid = v0; bus.req0_aluop = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_aluop = op1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    inj = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    tick();

    // rst, v0,op0,a0,b0, v1,op1,a1,b1, rdy0,rdy1,avi, rv0,rf0,ril0, rv1,rf1,ril1
    row(1, 1,0,1,1,      1,0,1,1,        0,0,0, 0,0,0,     0,0,0);      // r0 reset
    row(1, 1,0,1,1,      1,0,1,1,        0,0,0, 0,0,0,     0,0,0);      // r1 reset
    row(0, 1,0,5,6,      1,1,'hF0,'h3C,  1,0,1, 0,0,0,     0,0,0);      // r2 grant0
    row(0, 1,0,9,9,      1,1,'hF0,'h3C,  0,1,1, 0,0,0,     0,0,0);      // r3 grant1
    row(0, 1,4,10,3,     1,2,'hF0,'h0F,  1,0,1, 0,0,0,     0,0,0);      // r4 grant0
    row(0, 1,0,9,9,      1,2,'hF0,'h0F,  0,1,1, 1,11,0,    0,0,0);      // r5 grant1
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,11,0,    1,'h30,0);   // r6
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 1,7,0,     0,'h30,0);   // r7
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     1,'hFF,0);   // r8
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     0,'hFF,0);   // r9
    row(0, 1,4,10,3,     0,0,0,0,        1,0,1, 0,7,0,     0,'hFF,0);   // r10 single op
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     0,'hFF,0);   // r11
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     0,'hFF,0);   // r12
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 1,7,0,     0,'hFF,0);   // r13
    row(0, 0,0,0,0,      1,7,5,5,        0,1,0, 0,7,0,     0,'hFF,0);   // r14 illegal
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     0,'hFF,0);   // r15
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     0,'hFF,0);   // r16
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     1,0,1);      // r17
    row(0, 0,0,0,0,      1,3,'hFF,'h0F,  0,1,1, 0,7,0,     0,0,0);      // r18 lone req1
    row(0, 1,5,1,4,      0,0,0,0,        1,0,1, 0,7,0,     0,0,0);      // r19 lone req0
    row(0, 1,0,1,1,      1,6,'h80,3,     0,1,1, 0,7,0,     0,0,0);      // r20 prio=1
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,7,0,     1,'hF0,0);   // r21
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 1,16,0,    0,'hF0,0);   // r22
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,16,0,    1,'h10,0);   // r23
    row(0, 0,0,0,0,      0,0,0,0,        0,0,0, 0,16,0,    0,'h10,0);   // r24

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
            vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1);
      @(negedge clk);
      chk($sformatf("r%0d rdy0", i), 32'(bus.req0_ready), 32'(vecs[i].rdy0));
      chk($sformatf("r%0d rdy1", i), 32'(bus.req1_ready), 32'(vecs[i].rdy1));
      chk($sformatf("r%0d alu_valid_i", i), 32'(bus.alu_valid_i), 32'(vecs[i].avi));
      chk($sformatf("r%0d resp0_valid", i), 32'(bus.resp0_valid), 32'(vecs[i].rv0));
      chk($sformatf("r%0d resp0_f", i), bus.resp0_f, vecs[i].rf0);
      chk($sformatf("r%0d resp0_illegal", i), 32'(bus.resp0_illegal), 32'(vecs[i].ril0));
      chk($sformatf("r%0d resp1_valid", i), 32'(bus.resp1_valid), 32'(vecs[i].rv1));
      chk($sformatf("r%0d resp1_f", i), bus.resp1_f, vecs[i].rf1);
      chk($sformatf("r%0d resp1_illegal", i), 32'(bus.resp1_illegal), 32'(vecs[i].ril1));
      chk($sformatf("r%0d err", i), 32'(err), 32'h0);
      tick();
    end

    // Reset mid-flight: op from req1, op from req0 (prio ends at 1), then rst.
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd0, 32'd3, 32'd4);
    @(negedge clk);
    chk("mid rdy1 A", 32'(bus.req1_ready), 32'h1);
    tick();
    drive(1'b0, 1'b1, 3'd0, 32'd1, 32'd2, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid rdy0 B", 32'(bus.req0_ready), 32'h1);
    tick();
    drive(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid rdy0 in rst", 32'(bus.req0_ready), 32'h0);
    chk("mid alu_valid_i in rst", 32'(bus.alu_valid_i), 32'h0);
    tick();
    idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mid c%0d resp0_valid", k), 32'(bus.resp0_valid), 32'h0);
      chk($sformatf("mid c%0d resp1_valid", k), 32'(bus.resp1_valid), 32'h0);
      chk($sformatf("mid c%0d err", k), 32'(err), 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 3'd4, 32'd20, 32'd5, 1'b1, 3'd0, 32'd1, 32'd1);
    @(negedge clk);
    chk("post rdy0 prio reset", 32'(bus.req0_ready), 32'h1);
    chk("post rdy1 prio reset", 32'(bus.req1_ready), 32'h0);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("post resp0_valid", 32'(bus.resp0_valid), 32'h1);
    chk("post resp0_f", bus.resp0_f, 32'd15);
    chk("post resp1_f reset", bus.resp1_f, 32'h0);
    chk("post resp1_valid", 32'(bus.resp1_valid), 32'h0);
    tick();
    tick();

    // Error injection on an empty pipeline.
    inj = 1'b1;
    @(negedge clk);
    chk("inj err before", 32'(err), 32'h0);
    tick();
    inj = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("inj err sticky c%0d", k), 32'(err), 32'h1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("inj err cleared", 32'(err), 32'h0);
    tick();

`ifdef ALU_ARB_PERF_EN
    rst = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 3'd0, 32'(k), 32'd1, 1'b1, 3'd1, 32'(k), 32'd3);
      tick();
    end
    idle();
    @(negedge clk);
    chk("perf_grant0", perf_grant0, 32'd5);
    chk("perf_grant1", perf_grant1, 32'd5);
    chk("perf_conflict", perf_conflict, 32'd10);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
